// File: rtl/hci_tcdm_bank_responder_if.sv
// hci_mem_intf: one TCDM bank port (request/grant handshake, registered read data).
interface hci_mem_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [DW-1:0]   r_data;

    modport master (output req, add, wen, be, data, input gnt, r_data);
    modport slave  (input req, add, wen, be, data, output gnt, r_data);
endinterface

// File: rtl/hci_tcdm_bank_responder.sv
// hci_tcdm_bank_responder: NB_CHAN independent byte-enabled TCDM banks with grant
// stall injection, saturating read/write traffic counters and a sticky out-of-range flag.
module hci_tcdm_bank_responder #(
    parameter int unsigned NB_CHAN    = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned BANK_DEPTH = 256,
    parameter int unsigned COUNT_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    hci_mem_intf.slave         mem [NB_CHAN-1:0],
    input  logic [NB_CHAN-1:0] stall_i,
    output logic [COUNT_W-1:0] rd_count_o,
    output logic [COUNT_W-1:0] wr_count_o,
    output logic               oob_o
);
    localparam int unsigned IW = $clog2(BANK_DEPTH);
    localparam int unsigned NW = $clog2(NB_CHAN + 1);
    localparam int unsigned SW = (COUNT_W > NW ? COUNT_W : NW) + 1;
    localparam logic [COUNT_W-1:0] CMAX = '1;

    logic [NB_CHAN-1:0] rd_acc, wr_acc, oob_acc;
    logic [NW-1:0]      rd_n, wr_n;
    logic [SW-1:0]      rd_sum, wr_sum;

    for (genvar b = 0; b < NB_CHAN; b++) begin : g_bank
        logic [DW-1:0] words [BANK_DEPTH];
        logic [DW-1:0] r_data;
        logic [IW-1:0] idx;
        logic          acc, oob, unused_add;
        assign mem[b].gnt    = ~stall_i[b];
        assign mem[b].r_data = r_data;
        assign acc           = mem[b].req & ~stall_i[b];
        assign idx           = mem[b].add[IW+1:2];
        assign oob           = |mem[b].add[AW-1:IW+2];
        assign unused_add    = ^mem[b].add[1:0];
        assign rd_acc[b]     = acc & mem[b].wen;
        assign wr_acc[b]     = acc & ~mem[b].wen;
        assign oob_acc[b]    = acc & oob;

        // Out-of-range writes are dropped; out-of-range reads return a poison word.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_data <= '0;
                for (int i = 0; i < BANK_DEPTH; i++) words[i] <= '0;
            end else if (acc) begin
                if (mem[b].wen) r_data <= oob ? DW'(32'hDEAD_BEEF) : words[idx];
                else if (!oob)
                    for (int k = 0; k < DW/8; k++)
                        if (mem[b].be[k]) words[idx][8*k +: 8] <= mem[b].data[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_n = '0;
        wr_n = '0;
        for (int i = 0; i < NB_CHAN; i++) begin
            rd_n = rd_n + NW'(rd_acc[i]);
            wr_n = wr_n + NW'(wr_acc[i]);
        end
        rd_sum = SW'(rd_count_o) + SW'(rd_n);
        wr_sum = SW'(wr_count_o) + SW'(wr_n);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
            oob_o      <= 1'b0;
        end else if (clear_i) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
            oob_o      <= 1'b0;
        end else begin
            rd_count_o <= rd_sum > SW'(CMAX) ? CMAX : rd_sum[COUNT_W-1:0];
            wr_count_o <= wr_sum > SW'(CMAX) ? CMAX : wr_sum[COUNT_W-1:0];
            oob_o      <= oob_o | (|oob_acc);
        end
    end
endmodule

// File: tb/tb_hci_tcdm_bank_responder.sv
// tb_hci_tcdm_bank_responder: directed checks of byte enables, burst, stall, OOB,
// clear, counter saturation (COUNT_W=4) and asynchronous reset.
module tb_hci_tcdm_bank_responder;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [NB-1:0] stall_i = '0;
    logic [3:0]    rd_count, wr_count;
    logic          oob;

    logic [NB-1:0] req_v = '0, wen_v = '1, gnt_v;
    logic [31:0]   add_v [NB];
    logic [31:0]   data_v [NB];
    logic [3:0]    be_v [NB];
    logic [31:0]   rdata_v [NB];

    int total = 0;
    int bad = 0;

    hci_mem_intf #(.DW(32), .AW(32)) mem [NB-1:0] ();

    for (genvar g = 0; g < NB; g++) begin : g_port
        assign mem[g].req  = req_v[g];
        assign mem[g].wen  = wen_v[g];
        assign mem[g].add  = add_v[g];
        assign mem[g].data = data_v[g];
        assign mem[g].be   = be_v[g];
        assign gnt_v[g]    = mem[g].gnt;
        assign rdata_v[g]  = mem[g].r_data;
    end

    hci_tcdm_bank_responder #(
        .NB_CHAN(NB), .DW(32), .AW(32), .BANK_DEPTH(256), .COUNT_W(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .mem(mem),
        .stall_i(stall_i), .rd_count_o(rd_count), .wr_count_o(wr_count), .oob_o(oob)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_v = '0;
        wen_v = '1;
        stall_i = '0;
        clear_i = 1'b0;
    endtask

    task automatic wr(input int b, input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        req_v[b] = 1'b1;
        wen_v[b] = 1'b0;
        add_v[b] = a;
        data_v[b] = d;
        be_v[b] = e;
    endtask

    task automatic rd(input int b, input logic [31:0] a);
        req_v[b] = 1'b1;
        wen_v[b] = 1'b1;
        add_v[b] = a;
        data_v[b] = $urandom;
        be_v[b] = 4'($urandom);
    endtask

    initial begin
        // reset held with random traffic on every port
        for (int i = 0; i < NB; i++) begin
            add_v[i] = $urandom;
            data_v[i] = $urandom;
            be_v[i] = 4'($urandom);
        end
        req_v = 8'($urandom) | 8'h01;
        wen_v = 8'($urandom);
        stall_i = 8'hA5;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_v), 32'h5A);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_oob", 32'(oob), 0);
        chk("rst_rdata0", rdata_v[0], 0);
        chk("rst_rdata7", rdata_v[7], 0);
        idle();
        rst_ni = 1'b1;
        tick();

        // byte-enable merge on bank 3
        wr(3, 32'h10, 32'hAABB_CCDD, 4'b1111);
        tick();
        wr(3, 32'h10, 32'h1122_3344, 4'b0101);
        tick();
        rd(3, 32'h10);
        tick();
        idle();
        chk("be_rdata", rdata_v[3], 32'hAA22_CC44);
        chk("be_wr_count", 32'(wr_count), 2);
        chk("be_rd_count", 32'(rd_count), 1);
        tick();
        chk("be_hold", rdata_v[3], 32'hAA22_CC44);

        clear_i = 1'b1;
        tick();
        idle();
        chk("clr_rd", 32'(rd_count), 0);
        chk("clr_wr", 32'(wr_count), 0);

        // all-bank burst
        for (int i = 0; i < NB; i++) wr(i, 32'h4, 32'(i), 4'hF);
        tick();
        idle();
        chk("burst_wr_count", 32'(wr_count), 8);
        for (int i = 0; i < NB; i++) rd(i, 32'h4);
        tick();
        idle();
        for (int i = 0; i < NB; i++) chk($sformatf("burst_rdata%0d", i), rdata_v[i], 32'(i));
        chk("burst_rd_count", 32'(rd_count), 8);

        // stall on bank 2 with a held read
        wr(2, 32'h8, 32'hCAFE_F00D, 4'hF);
        tick();
        idle();
        clear_i = 1'b1;
        tick();
        idle();
        stall_i[2] = 1'b1;
        rd(2, 32'h8);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_gnt", 32'(gnt_v[2]), 0);
            chk("stall_rdata", rdata_v[2], 2);
            chk("stall_rd_count", 32'(rd_count), 0);
        end
        stall_i[2] = 1'b0;
        #1;
        chk("unstall_gnt", 32'(gnt_v[2]), 1);
        tick();
        idle();
        chk("unstall_rdata", rdata_v[2], 32'hCAFE_F00D);
        chk("unstall_rd_count", 32'(rd_count), 1);

        // out-of-range accesses on bank 1 (0x400 aliases word 0 if decoded wrongly)
        clear_i = 1'b1;
        tick();
        idle();
        wr(1, 32'h400, 32'h1234_5678, 4'hF);
        tick();
        idle();
        chk("oob_set", 32'(oob), 1);
        chk("oob_wr_count", 32'(wr_count), 1);
        rd(1, 32'h400);
        tick();
        chk("oob_rdata", rdata_v[1], 32'hDEAD_BEEF);
        rd(1, 32'h0);
        tick();
        idle();
        chk("oob_discard", rdata_v[1], 0);
        chk("oob_sticky", 32'(oob), 1);
        rd(1, 32'h400);
        clear_i = 1'b1;
        tick();
        idle();
        chk("clr_oob_override", 32'(oob), 0);
        chk("clr_rd_override", 32'(rd_count), 0);
        chk("clr_wr", 32'(wr_count), 0);
        chk("clr_read_accepted", rdata_v[1], 32'hDEAD_BEEF);
        rd(1, 32'h4);
        rd(3, 32'h10);
        tick();
        idle();
        chk("intact_b1", rdata_v[1], 1);
        chk("intact_b3", rdata_v[3], 32'hAA22_CC44);

        // saturation of the 4-bit read counter
        clear_i = 1'b1;
        tick();
        idle();
        for (int i = 0; i < NB; i++) rd(i, 32'h4);
        tick();
        chk("sat_first", 32'(rd_count), 8);
        tick();
        chk("sat_clamp", 32'(rd_count), 15);
        tick();
        idle();
        chk("sat_stay", 32'(rd_count), 15);
        tick();
        chk("sat_idle", 32'(rd_count), 15);

        // asynchronous reset mid-operation clears memory and outputs
        rd(3, 32'h10);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_rdata2", rdata_v[2], 0);
        chk("arst_rd_count", 32'(rd_count), 0);
        idle();
        tick();
        rst_ni = 1'b1;
        rd(3, 32'h10);
        tick();
        idle();
        chk("arst_mem_cleared", rdata_v[3], 0);
        chk("arst_rd_count_restart", 32'(rd_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
